// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath widths and helpers for the MIPS pipeline stages
package mips_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_W      = 5;
   localparam int BYTE_OFF_W = 2;

   typedef struct packed {
      logic              to_wb;
      logic              mem_to_reg;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rdata;
      logic [REG_W-1:0]  rd;
   } memwb_t;

   function automatic logic is_misaligned(input logic wr, input logic rd,
                                          input logic [DATA_W-1:0] addr);
      return (wr | rd) & (addr[BYTE_OFF_W-1:0] != '0);
   endfunction
endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - EX/MEM inputs and MEM/WB outputs of the memory stage
interface mem_wb_stage_if;
   import mips_pkg::*;

   logic              i_toWB;
   logic              i_memWRITE;
   logic              i_memToREG;
   logic [DATA_W-1:0] i_ALUout;
   logic [DATA_W-1:0] i_datamem;
   logic [REG_W-1:0]  i_rd3;

   logic              o_toWB;
   logic              o_memToREG;
   logic [DATA_W-1:0] o_ALUout;
   logic [DATA_W-1:0] o_readdata;
   logic [REG_W-1:0]  o_rd4;
   logic              o_fault;
   logic [DATA_W-1:0] o_fault_addr;

   modport master (
      output i_toWB, i_memWRITE, i_memToREG, i_ALUout, i_datamem, i_rd3,
      input  o_toWB, o_memToREG, o_ALUout, o_readdata, o_rd4, o_fault, o_fault_addr
   );

   modport slave (
      input  i_toWB, i_memWRITE, i_memToREG, i_ALUout, i_datamem, i_rd3,
      output o_toWB, o_memToREG, o_ALUout, o_readdata, o_rd4, o_fault, o_fault_addr
   );
endinterface

// File: rtl/mem_wb_stage_data_ram.sv
// rtl/mem_wb_stage_data_ram.sv - word data RAM, one synchronous write port, one async read port
module data_ram
   import mips_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk_l,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   // Contents are deliberately not reset.
   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge i_clk_l) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage: word load/store on local RAM, MEM/WB register, sticky fault
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic           i_clk_l,
   input  logic           i_rst,
   input  logic           i_stall,
   input  logic           i_flush,
   mem_wb_stage_if.slave  bus
);
   memwb_t            wb_q, wb_d;
   logic              fault_q, fault_d;
   logic [DATA_W-1:0] fault_addr_q, fault_addr_d;

   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] ram_rdata;
   logic              misaligned;
   logic              accept;
   logic              ram_we;

   assign idx        = bus.i_ALUout[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
   assign misaligned = is_misaligned(bus.i_memWRITE, bus.i_memToREG, bus.i_ALUout);
   assign accept     = !i_rst && !i_stall && !i_flush;
   assign ram_we     = accept && bus.i_memWRITE && !misaligned;

   data_ram #(.ADDR_W(ADDR_W)) u_ram (
      .i_clk_l (i_clk_l),
      .i_we    (ram_we),
      .i_waddr (idx),
      .i_wdata (bus.i_datamem),
      .i_raddr (idx),
      .o_rdata (ram_rdata)
   );

   always_comb begin
      wb_d         = wb_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      if (i_flush) begin
         wb_d = '0;
      end else if (!i_stall) begin
         wb_d.alu        = bus.i_ALUout;
         wb_d.rd         = bus.i_rd3;
         wb_d.rdata      = ram_rdata;
         // A simultaneous load+store request behaves as a store: no writeback.
         wb_d.mem_to_reg = bus.i_memToREG && !bus.i_memWRITE;
         wb_d.to_wb      = bus.i_toWB && !misaligned && !(bus.i_memWRITE && bus.i_memToREG);
      end
      if (accept && misaligned && !fault_q) begin
         fault_d      = 1'b1;
         fault_addr_d = bus.i_ALUout;
      end
   end

   always_ff @(posedge i_clk_l) begin
      if (i_rst) begin
         wb_q         <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         wb_q         <= wb_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign bus.o_toWB       = wb_q.to_wb;
   assign bus.o_memToREG   = wb_q.mem_to_reg;
   assign bus.o_ALUout     = wb_q.alu;
   assign bus.o_readdata   = wb_q.rdata;
   assign bus.o_rd4        = wb_q.rd;
   assign bus.o_fault      = fault_q;
   assign bus.o_fault_addr = fault_addr_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with a word-array reference model
module tb_mem_wb_stage;
   logic clk = 1'b0;
   logic rst, stall, flush;

   mem_wb_stage_if bif ();

   mem_wb_stage #(.ADDR_W(8)) dut (
      .i_clk_l (clk),
      .i_rst   (rst),
      .i_stall (stall),
      .i_flush (flush),
      .bus     (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          to_wb;
      bit          mtr;
      bit [31:0]   alu;
      bit [31:0]   rdata;
      bit [4:0]    rd;
      bit          fault;
      bit [31:0]   faddr;
      bit          rdata_known;
   } exp_t;

   exp_t      expq[$];
   exp_t      cur;
   bit [31:0] ram   [256];
   bit        known [256];
   int        checks = 0;
   int        errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected MEM/WB contents after the coming edge, from the architectural rules.
   task automatic step(input bit r, input bit st, input bit fl, input bit twb,
                       input bit mw, input bit mr, input bit [31:0] a,
                       input bit [31:0] d, input bit [4:0] rd3);
      int unsigned w;
      bit mis, acc;
      @(negedge clk);
      rst = r; stall = st; flush = fl;
      bif.i_toWB = twb; bif.i_memWRITE = mw; bif.i_memToREG = mr;
      bif.i_ALUout = a; bif.i_datamem = d; bif.i_rd3 = rd3;
      w   = (a / 4) % 256;
      mis = (mw || mr) && (a % 4 != 0);
      acc = !r && !st && !fl;
      if (r) begin
         cur = '{default: 0};
         cur.rdata_known = 1;
      end else begin
         if (fl) begin
            cur.to_wb = 0; cur.mtr = 0; cur.alu = 0; cur.rdata = 0; cur.rd = 0;
            cur.rdata_known = 1;
         end else if (!st) begin
            cur.alu = a; cur.rd = rd3;
            cur.rdata = ram[w]; cur.rdata_known = known[w];
            cur.mtr = mr && !mw;
            cur.to_wb = twb && !mis && !(mw && mr);
         end
         if (acc && mis && !cur.fault) begin
            cur.fault = 1;
            cur.faddr = a;
         end
         if (acc && mw && !mis) begin
            ram[w] = d;
            known[w] = 1;
         end
      end
      expq.push_back(cur);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("o_toWB", {31'd0, bif.o_toWB}, {31'd0, e.to_wb});
            chk("o_memToREG", {31'd0, bif.o_memToREG}, {31'd0, e.mtr});
            chk("o_ALUout", bif.o_ALUout, e.alu);
            chk("o_rd4", {27'd0, bif.o_rd4}, {27'd0, e.rd});
            chk("o_fault", {31'd0, bif.o_fault}, {31'd0, e.fault});
            chk("o_fault_addr", bif.o_fault_addr, e.faddr);
            if (e.rdata_known) chk("o_readdata", bif.o_readdata, e.rdata);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int unsigned a, k;
      rst = 1; stall = 0; flush = 0;
      bif.i_toWB = 0; bif.i_memWRITE = 0; bif.i_memToREG = 0;
      bif.i_ALUout = 0; bif.i_datamem = 0; bif.i_rd3 = 0;
      cur = '{default: 0};
      for (int i = 0; i < 256; i++) known[i] = 0;

      // Reset with random inputs.
      repeat (2) step(1, $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
                      $urandom_range(0,1), $urandom_range(0,1), $urandom, $urandom, 5'($urandom));
      // Fill every word so loads have defined contents.
      for (int i = 0; i < 256; i++) step(0, 0, 0, 0, 1, 0, i * 4, $urandom, 0);

      // Store then load same word.
      step(0, 0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 0);
      step(0, 0, 0, 1, 0, 1, 32'h10, 0, 7);
      // Address wrap.
      step(0, 0, 0, 0, 1, 0, 32'h400, 32'h12345678, 0);
      step(0, 0, 0, 1, 0, 1, 32'h000, 0, 3);
      // Both load and store set: store, no writeback.
      step(0, 0, 0, 1, 1, 1, 32'h44, 32'hCAFEF00D, 9);
      step(0, 0, 0, 1, 0, 1, 32'h44, 0, 9);
      // Stall holds outputs and blocks the store, then release commits it.
      step(0, 1, 0, 1, 1, 0, 32'h20, 32'hAAAA5555, 4);
      step(0, 1, 0, 1, 1, 0, 32'h20, 32'hAAAA5555, 4);
      step(0, 0, 0, 1, 0, 1, 32'h20, 0, 5);
      step(0, 0, 0, 0, 1, 0, 32'h20, 32'hAAAA5555, 0);
      step(0, 0, 0, 1, 0, 1, 32'h20, 0, 6);
      // Flush together with stall.
      step(0, 1, 1, 1, 1, 0, 32'h30, 32'h0BADBAD0, 2);
      step(0, 0, 0, 1, 0, 1, 32'h30, 0, 2);
      // Flushed / stalled misaligned accesses do not fault.
      step(0, 0, 1, 1, 0, 1, 32'h31, 0, 1);
      step(0, 1, 0, 1, 0, 1, 32'h32, 0, 1);
      // First fault latches its address; a later one does not move it.
      step(0, 0, 0, 1, 0, 1, 32'h13, 0, 8);
      step(0, 0, 0, 0, 1, 0, 32'h21, 32'h55555555, 0);
      step(0, 0, 0, 1, 0, 1, 32'h20, 0, 8);

      // Randomized traffic over a small word window to provoke reuse.
      for (int n = 0; n < 3000; n++) begin
         k = $urandom_range(0, 99);
         a = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 19) == 0) a = a | $urandom_range(1, 3);
         step(k == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 1),
              a, $urandom, 5'($urandom));
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int t = 0; t < 10 && expq.size() > 0; t++) @(negedge clk);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
